apu_frame_seq_gen2: RTL and testbench
=====================================

// Module: apu_frame_seq_gen2
// PURPOSE
//  Parametrised next-generation APU frame sequencer (LFO/"soft timer"). A binary step counter
//  with programmable thresholds replaces the fixed LFSR+PLA decode. It generates the quarter-frame
//  (LFO1) and half-frame (LFO2) strobes for envelope/length/sweep units, plus the frame IRQ.
//  Sits beside the $4015/$4017 register decode; feeds all tone/noise channel sequencers.
// PARAMETERS
//  CNT_W     15        step counter width
//  T0..T4    3728,7456,11185,14914,18640  step match values; T0<T1<T2<T3<T4<2**CNT_W
//  QF_MASK4  5'b01111  per-step (bit k = step k) quarter-frame enable, 4-step mode
//  HF_MASK4  5'b01010  per-step half-frame enable, 4-step mode
//  QF_MASK5  5'b10111  per-step quarter-frame enable, 5-step mode
//  HF_MASK5  5'b10010  per-step half-frame enable, 5-step mode
//  WR_DELAY  3         cycles from a W4017 write to the counter restart (>=1)
// PORTS
//  ACLK1     in   1  clock, one rising edge per APU cycle
//  RES       in   1  synchronous reset, active high
//  W4017     in   1  one-cycle write strobe for mode register
//  R4015     in   1  one-cycle status read strobe (clears frame IRQ flag)
//  DB_in     in   8  write data; [7]=mode (1=5-step), [6]=IRQ inhibit
//  step_en   in   1  counter advance enable (0 = stall, debug)
//  DMCINT    in   1  DMC interrupt, ORed into INT_out
//  LFO1      out  1  quarter-frame strobe, one cycle
//  LFO2      out  1  half-frame strobe, one cycle
//  INT_out   out  1  frame IRQ flag OR DMCINT
//  irq_flag  out  1  frame IRQ flag (status bit 6)
//  mode      out  1  current mode bit
//  step_idx  out  3  index of the last step reached (0..4)
// BEHAVIOUR
//  Reset (RES=1 at edge): cnt=0, mode=0, inhibit=0, irq_flag=0, LFO1=LFO2=0, step_idx=0,
//   pending=0, delay counter=0. RES overrides every other input, including mid-pending writes.
//  Counter: when step_en=1 and no pending restart, cnt increments each cycle. Last step is
//   T3 (mode=0) or T4 (mode=1); the cycle after cnt==Tlast, cnt=0 (wrap). step_en=0 freezes cnt;
//   no strobes are emitted while frozen.
//  Step hit: when cnt==Tk (k<=last) with step_en=1, on the next edge: LFO1=QF_MASKm[k],
//   LFO2=HF_MASKm[k], step_idx=k. Latency: 1 cycle, strobes are registered, high exactly 1 cycle.
//  IRQ: in mode 0 with inhibit=0, a T3 hit sets irq_flag (same edge as the strobes). Mode 1 never
//   sets it. R4015 clears irq_flag at the edge; a simultaneous set and R4015 -> set wins (flag=1).
//  Write: W4017 at edge loads mode<=DB_in[7], inhibit<=DB_in[6] immediately; DB_in[6]=1 also
//   clears irq_flag at that edge. It arms pending with delay=WR_DELAY. Each cycle, delay
//   decrements; the edge at which it reaches 0: cnt<=0, pending<=0, and if mode=1
//   LFO1=LFO2=1 for that one cycle. Counter does not advance or hit steps while pending.
//  A second W4017 during pending reloads the register bits and restarts delay at WR_DELAY.
//  Mode changes only via W4017 (no mid-frame switch); pending restart occurs regardless of step_en.
//  INT_out = irq_flag | DMCINT (combinational OR of registered flag).
// TESTING
//  1 RES, mode 0, step_en=1: LFO1 pulses at cycles T0+1,T1+1,T2+1,T3+1; LFO2 at T1+1,T3+1;
//    irq_flag=1 at T3+1; cnt wraps to 0 at T3+1; repeats with period T3+1.
//  2 W4017 DB_in=8'h80 at cycle c: mode=1 at c+1; LFO1=LFO2=1 at c+WR_DELAY; next LFO1 at
//    c+WR_DELAY+T0+1; no LFO1 at step 3; wrap period T4+1; irq_flag never set.
//  3 irq_flag=1, W4017 DB_in=8'h40: irq_flag=0 next edge; following T3 hit leaves it 0.
//  4 R4015 asserted the same edge as a T3 hit -> irq_flag=1; R4015 one cycle later -> 0;
//    DMCINT=1 with irq_flag=0 -> INT_out=1.
//  5 W4017 8'h80 then RES one cycle later: all outputs 0, mode=0, no restart strobe emitted.
//  6 step_en=0 for 100 cycles before T1: LFO1 at T1 delayed by exactly 100 cycles; double write
//    2 cycles apart -> single restart strobe, WR_DELAY after the second write.

Source files
------------

// File: rtl/apu_frame_seq_gen2_if.sv
// Frame sequencer bus: groups the register strobes, write data, debug stall enable and DMC
// interrupt input, together with the strobe, status and interrupt outputs of the sequencer.
//   master : register decode / channel side (drives strobes and data, observes outputs)
//   slave  : the frame sequencer itself
// Signals:
//   W4017    mode register write strobe (one cycle)
//   R4015    status read strobe (clears the frame IRQ flag)
//   DB_in    write data, [7] = 5-step mode, [6] = IRQ inhibit
//   step_en  counter advance enable (0 stalls the sequencer)
//   DMCINT   DMC interrupt, merged into INT_out
//   LFO1     quarter-frame strobe
//   LFO2     half-frame strobe
//   INT_out  frame IRQ flag OR DMCINT
//   irq_flag frame IRQ flag
//   mode     current mode bit
//   step_idx index of the last step reached
interface apu_frame_seq_gen2_if;
    logic       W4017;
    logic       R4015;
    logic [7:0] DB_in;
    logic       step_en;
    logic       DMCINT;
    logic       LFO1;
    logic       LFO2;
    logic       INT_out;
    logic       irq_flag;
    logic       mode;
    logic [2:0] step_idx;

    modport master (
        output W4017, R4015, DB_in, step_en, DMCINT,
        input  LFO1, LFO2, INT_out, irq_flag, mode, step_idx
    );

    modport slave (
        input  W4017, R4015, DB_in, step_en, DMCINT,
        output LFO1, LFO2, INT_out, irq_flag, mode, step_idx
    );
endinterface

// File: rtl/apu_frame_seq_gen2.sv
// APU frame sequencer: a binary step counter compared against programmable thresholds produces
// the quarter-frame (LFO1) and half-frame (LFO2) strobes and the frame IRQ flag.
// Ports:
//   ACLK1  clock, one rising edge per APU cycle
//   RES    synchronous reset, active high
//   bus    apu_frame_seq_gen2_if.slave (register strobes/data in; strobes, flags, mode out)
module apu_frame_seq_gen2 #(
    parameter int unsigned CNT_W    = 15,
    parameter int unsigned T0       = 3728,
    parameter int unsigned T1       = 7456,
    parameter int unsigned T2       = 11185,
    parameter int unsigned T3       = 14914,
    parameter int unsigned T4       = 18640,
    parameter logic [4:0]  QF_MASK4 = 5'b01111,
    parameter logic [4:0]  HF_MASK4 = 5'b01010,
    parameter logic [4:0]  QF_MASK5 = 5'b10111,
    parameter logic [4:0]  HF_MASK5 = 5'b10010,
    parameter int unsigned WR_DELAY = 3
) (
    input  logic                 ACLK1,
    input  logic                 RES,
    apu_frame_seq_gen2_if.slave  bus
);

    localparam int unsigned DLY_W = (WR_DELAY < 2) ? 1 : $clog2(WR_DELAY + 1);

    localparam logic [CNT_W-1:0] THR [5] = '{
        CNT_W'(T0), CNT_W'(T1), CNT_W'(T2), CNT_W'(T3), CNT_W'(T4)
    };

    typedef enum logic {StRun, StPending} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0] delay_q, delay_d;
    logic             mode_q, mode_d;
    logic             inhibit_q, inhibit_d;
    logic             irq_q, irq_d;
    logic             lfo1_q, lfo1_d;
    logic             lfo2_q, lfo2_d;
    logic [2:0]       step_idx_q, step_idx_d;

    logic             advance;
    logic [4:0]       hit;
    logic             hit_any;
    logic [2:0]       hit_idx;
    logic [CNT_W-1:0] last_cnt;
    logic [4:0]       qf_mask;
    logic [4:0]       hf_mask;
    logic             irq_set;

    // Step decode; step 4 only exists in 5-step mode. Thresholds are distinct, so hit is one-hot.
    always_comb begin
        hit      = '0;
        hit_idx  = 3'd0;
        for (int k = 0; k < 5; k++) begin
            hit[k] = (cnt_q == THR[k]) && ((k != 4) || mode_q);
            if (hit[k]) begin
                hit_idx = 3'(k);
            end
        end
        hit_any  = |hit;
        last_cnt = mode_q ? THR[4] : THR[3];
        qf_mask  = mode_q ? QF_MASK5 : QF_MASK4;
        hf_mask  = mode_q ? HF_MASK5 : HF_MASK4;
        advance  = (state_q == StRun) && bus.step_en;
        irq_set  = advance && hit[3] && !mode_q && !inhibit_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        delay_d    = delay_q;
        mode_d     = mode_q;
        inhibit_d  = inhibit_q;
        irq_d      = irq_q;
        lfo1_d     = 1'b0;
        lfo2_d     = 1'b0;
        step_idx_d = step_idx_q;

        if (advance) begin
            // >= rather than == keeps the counter bounded even from an unexpected value.
            cnt_d = (cnt_q >= last_cnt) ? '0 : cnt_q + CNT_W'(1);
            if (hit_any) begin
                lfo1_d     = qf_mask[hit_idx];
                lfo2_d     = hf_mask[hit_idx];
                step_idx_d = hit_idx;
            end
        end

        // A status read loses against a simultaneous frame IRQ.
        if (bus.R4015) begin
            irq_d = 1'b0;
        end
        if (irq_set) begin
            irq_d = 1'b1;
        end

        if (bus.W4017) begin
            mode_d    = bus.DB_in[7];
            inhibit_d = bus.DB_in[6];
            if (bus.DB_in[6]) begin
                irq_d = 1'b0;
            end
            state_d = StPending;
            delay_d = DLY_W'(WR_DELAY);
        end else if (state_q == StPending) begin
            delay_d = delay_q - DLY_W'(1);
            if (delay_q == DLY_W'(1)) begin
                state_d = StRun;
                cnt_d   = '0;
                // A restart into 5-step mode clocks the envelope/length units immediately.
                if (mode_q) begin
                    lfo1_d = 1'b1;
                    lfo2_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ACLK1) begin
        if (RES) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            delay_q    <= '0;
            mode_q     <= 1'b0;
            inhibit_q  <= 1'b0;
            irq_q      <= 1'b0;
            lfo1_q     <= 1'b0;
            lfo2_q     <= 1'b0;
            step_idx_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            delay_q    <= delay_d;
            mode_q     <= mode_d;
            inhibit_q  <= inhibit_d;
            irq_q      <= irq_d;
            lfo1_q     <= lfo1_d;
            lfo2_q     <= lfo2_d;
            step_idx_q <= step_idx_d;
        end
    end

    assign bus.LFO1     = lfo1_q;
    assign bus.LFO2     = lfo2_q;
    assign bus.irq_flag = irq_q;
    assign bus.mode     = mode_q;
    assign bus.step_idx = step_idx_q;
    assign bus.INT_out  = irq_q | bus.DMCINT;

endmodule

// File: tb/tb_apu_frame_seq_gen2.sv
// Randomized bench for apu_frame_seq_gen2 against a frame-position reference model.
// Short thresholds keep many frames within the run.
module tb_apu_frame_seq_gen2;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned T0       = 10;
    localparam int unsigned T1       = 21;
    localparam int unsigned T2       = 33;
    localparam int unsigned T3       = 46;
    localparam int unsigned T4       = 58;
    localparam int unsigned WR_DELAY = 3;
    localparam int unsigned N_CYC    = 20000;

    logic clk = 1'b0;
    logic res;

    apu_frame_seq_gen2_if bus ();

    apu_frame_seq_gen2 #(
        .CNT_W    (CNT_W),
        .T0       (T0),
        .T1       (T1),
        .T2       (T2),
        .T3       (T3),
        .T4       (T4),
        .QF_MASK4 (5'b01111),
        .HF_MASK4 (5'b01010),
        .QF_MASK5 (5'b10111),
        .HF_MASK5 (5'b10010),
        .WR_DELAY (WR_DELAY)
    ) dut (
        .ACLK1 (clk),
        .RES   (res),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: position within the frame, restart countdown and register bits.
    int thr [5];
    int qf4 = 'b01111, hf4 = 'b01010, qf5 = 'b10111, hf5 = 'b10010;
    int m_pos, m_dly, m_idx;
    bit m_pend, m_mode, m_inh, m_irq, m_l1, m_l2;

    task automatic model_reset();
        m_pos = 0; m_dly = 0; m_idx = 0;
        m_pend = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_l1 = 0; m_l2 = 0;
    endtask

    task automatic model_step(input bit r_res, input bit w, input bit rd, input logic [7:0] db,
                              input bit en);
        int last;
        int hit;
        if (r_res) begin
            model_reset();
            return;
        end
        m_l1 = 0;
        m_l2 = 0;
        hit  = -1;
        last = m_mode ? 4 : 3;
        if (!m_pend && en) begin
            for (int k = 0; k <= last; k++) begin
                if (m_pos == thr[k]) hit = k;
            end
            if (hit >= 0) begin
                m_l1  = ((m_mode ? qf5 : qf4) >> hit) & 1;
                m_l2  = ((m_mode ? hf5 : hf4) >> hit) & 1;
                m_idx = hit;
            end
            m_pos = (m_pos >= thr[last]) ? 0 : m_pos + 1;
        end
        if (rd) m_irq = 0;
        if (hit == 3 && !m_mode && !m_inh) m_irq = 1;
        if (w) begin
            m_mode = db[7];
            m_inh  = db[6];
            if (db[6]) m_irq = 0;
            m_pend = 1;
            m_dly  = WR_DELAY;
        end else if (m_pend) begin
            m_dly--;
            if (m_dly == 0) begin
                m_pend = 0;
                m_pos  = 0;
                if (m_mode) begin
                    m_l1 = 1;
                    m_l2 = 1;
                end
            end
        end
    endtask

    task automatic compare_all(input int cyc);
        check_val($sformatf("LFO1@%0d", cyc), 32'(bus.LFO1), 32'(m_l1));
        check_val($sformatf("LFO2@%0d", cyc), 32'(bus.LFO2), 32'(m_l2));
        check_val($sformatf("irq_flag@%0d", cyc), 32'(bus.irq_flag), 32'(m_irq));
        check_val($sformatf("mode@%0d", cyc), 32'(bus.mode), 32'(m_mode));
        check_val($sformatf("step_idx@%0d", cyc), 32'(bus.step_idx), 32'(m_idx));
        check_val($sformatf("INT_out@%0d", cyc), 32'(bus.INT_out), 32'(m_irq | bus.DMCINT));
    endtask

    initial begin
        bit         r_res, w, rd, en, dmc;
        logic [7:0] db;
        int         wr_again;
        int         stall_left;

        thr = '{T0, T1, T2, T3, T4};
        wr_again   = 0;
        stall_left = 0;

        res         = 1'b1;
        bus.W4017   = 1'b0;
        bus.R4015   = 1'b0;
        bus.DB_in   = 8'h00;
        bus.step_en = 1'b1;
        bus.DMCINT  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_all(-1);

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            r_res = ($urandom_range(0, 2999) == 0);

            w = 1'b0;
            if (wr_again > 0) begin
                wr_again--;
                w = (wr_again == 0);
            end else if ($urandom_range(0, 349) == 0) begin
                w = 1'b1;
                // Sometimes follow up with a second write while the restart is still pending.
                if ($urandom_range(0, 3) == 0) wr_again = 2;
            end
            db = 8'($urandom);

            rd = ($urandom_range(0, 29) == 0);

            if (stall_left > 0) begin
                stall_left--;
                en = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                stall_left = $urandom_range(1, 120);
                en = 1'b0;
            end else begin
                en = 1'b1;
            end

            dmc = ($urandom_range(0, 7) == 0);

            res         = r_res;
            bus.W4017   = w;
            bus.R4015   = rd;
            bus.DB_in   = db;
            bus.step_en = en;
            bus.DMCINT  = dmc;
            model_step(r_res, w, rd, db, en);

            @(negedge clk);
            compare_all(cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
